// File: rtl/blockstacker_pkg.sv
// blockstacker_pkg: shared state encoding and default screen geometry for the block game.
package blockstacker_pkg;
  typedef enum logic [1:0] {MOVE, DROP, TOP} state_t;
  localparam int X_MAX_DEF = 156;
  localparam int Y_START_DEF = 115;
  localparam int STEP_DEF = 4;
  localparam int Y_TOP_DEF = 3;
endpackage

// File: rtl/step_timer.sv
// step_timer: free-running period counter that emits one tick per period while enabled.
module step_timer #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);
  logic [DIV_W-1:0] cnt, lim;
  // Compare with >= so that shrinking the period mid-count still wraps immediately.
  assign lim = (period == '0) ? '0 : period - DIV_W'(1);
  assign tick = en && !clear && cnt >= lim;
  always_ff @(posedge clk) begin
    if (!reset || clear) cnt <= '0;
    else if (en) cnt <= (cnt >= lim) ? '0 : cnt + DIV_W'(1);
  end
endmodule

// File: rtl/block_mover.sv
// block_mover: bounces a block horizontally and raises it one row per drop request until the top.
module block_mover
  import blockstacker_pkg::*;
#(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int X_MAX   = X_MAX_DEF,
  parameter int X_STEP  = STEP_DEF,
  parameter int Y_START = Y_START_DEF,
  parameter int Y_STEP  = STEP_DEF,
  parameter int Y_TOP   = Y_TOP_DEF,
  parameter int DIV_W   = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             move_en,
  input  logic [DIV_W-1:0] period,
  input  logic             drop_req,
  input  logic [2:0]       colour_in,
  input  logic             colour_erase_enable,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [2:0]       colour,
  output logic             dir,
  output logic             drop_ack,
  output logic             at_top
);
  localparam logic [X_W:0] XMAX_E = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] XSTEP_E = (X_W+1)'(X_STEP);
  localparam logic [X_W-1:0] XS = X_W'(X_STEP);
  localparam logic [Y_W-1:0] YS = Y_W'(Y_STEP);
  localparam logic [Y_W-1:0] YT = Y_W'(Y_TOP);
  localparam logic [Y_W-1:0] YST = Y_W'(Y_START);
  state_t state, state_nx;
  logic tick, drop_go, right_hit, left_hit, dir_nx;
  logic [X_W-1:0] x_nx;
  assign drop_go = state == MOVE && drop_req;
  step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk(clk), .reset(reset), .en(move_en && state == MOVE), .clear(drop_go),
    .period(period), .tick(tick)
  );
  // Extra bit keeps x + X_STEP from wrapping before the bound test.
  assign right_hit = ({1'b0, x} + XSTEP_E) > XMAX_E;
  assign left_hit = {1'b0, x} < XSTEP_E;
  always_comb begin
    state_nx = state == DROP ? MOVE : drop_go ? (y > YT ? DROP : TOP) : state;
    x_nx = (dir ? right_hit : !left_hit) ? x - XS : x + XS;
    dir_nx = dir ? !right_hit : left_hit;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MOVE;
      x <= '0;
      y <= YST;
      dir <= 1'b1;
    end else begin
      state <= state_nx;
      if (state_nx == DROP) y <= y - YS;
      if (tick) begin
        x <= x_nx;
        dir <= dir_nx;
      end
    end
  end
  assign drop_ack = state == DROP;
  assign at_top = state == TOP;
  assign colour = colour_erase_enable ? 3'b000 : colour_in;
endmodule
